fp_fir_mac_sequencer: RTL and testbench

Time-multiplexed controller for the floating-point FIR datapath. One shared FP_Multiplier_Single and one shared Floating_Point_Addition_New, both external and combinational, compute an NTAPS-tap IEEE-754 single-precision FIR. The block owns the sample delay line and the coefficient bank, steps one tap per cycle, and presents each filtered output with valid/ready handshakes. It replaces the NTAPS-multiplier parallel FIR where area matters.

---
 rtl/fp_fir_mac_sequencer_if.sv | 41 ++++
 rtl/fp_fir_mac_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fp_fir_mac_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_fir_mac_sequencer_if.sv
// ============================================================================
// Module  : fp_fir_mac_sequencer_if
// Purpose : Sample/result handshakes, coefficient port and shared FP operator
//           bus of the time-multiplexed FIR sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fp_fir_mac_sequencer_if #(
    parameter int AW = 2
);
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_data;
    logic          cfg_err;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic [31:0]   mul_p;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic [31:0]   add_s;

    // Environment side: sample source, result sink, config host and the FP operators.
    modport master (
        output in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data, mul_p, add_s,
        input  in_ready, out_data, out_valid, cfg_err, mul_a, mul_b, add_a, add_b
    );

    modport slave (
        input  in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data, mul_p, add_s,
        output in_ready, out_data, out_valid, cfg_err, mul_a, mul_b, add_a, add_b
    );
endinterface

`default_nettype wire

// File: rtl/fp_fir_mac_sequencer.sv
// ============================================================================
// Module  : fp_fir_mac_sequencer
// Purpose : One-tap-per-cycle FIR controller driving an external FP multiplier
//           and adder; owns the delay line and coefficient bank.
//           Optional macro FIR_SEQ_PROD_REG_EN registers the product (p_q).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_fir_mac_sequencer #(
    parameter int NTAPS = 4,
    parameter int AW    = 2
) (
    input  wire                    Clk,
    input  wire                    Rst,
    fp_fir_mac_sequencer_if.slave  bus
);

    localparam int c_CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [31:0]     r_x    [NTAPS];
    logic [31:0]     r_coef [NTAPS];
    logic [31:0]     r_acc;
    logic [31:0]     r_out_data;
    logic            r_out_valid;
    logic            r_cfg_err;
    logic [c_CW-1:0] r_k;

    logic [AW-1:0]   w_tap;
    logic            w_addr_ok;
    logic            w_cfg_ok;
    logic            w_issue;
    logic            w_first;
    logic            w_consume;
    logic            w_last;
    logic [31:0]     w_prod;
    logic            w_in_ready;
    logic [31:0]     w_mul_a;
    logic [31:0]     w_mul_b;
    logic [31:0]     w_add_a;
    logic [31:0]     w_add_b;

    assign w_tap     = r_k[AW-1:0];
    assign w_addr_ok = (32'(bus.cfg_addr) < 32'(NTAPS));
    assign w_cfg_ok  = bus.cfg_we && (r_state == S_IDLE) && w_addr_ok;

`ifdef FIR_SEQ_PROD_REG_EN
    // Tap j is issued at count j and consumed at count j+1, so MAC runs NTAPS+1 cycles.
    logic [31:0] r_p_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_p_q <= '0;
        end else begin
            r_p_q <= bus.mul_p;
        end
    end

    assign w_prod    = r_p_q;
    assign w_issue   = (r_k < c_CW'(NTAPS));
    assign w_first   = (r_k == c_CW'(1));
    assign w_consume = (r_k != '0);
    assign w_last    = (r_k == c_CW'(NTAPS));
`else
    assign w_prod    = bus.mul_p;
    assign w_issue   = 1'b1;
    assign w_first   = (r_k == '0);
    assign w_consume = 1'b1;
    assign w_last    = (r_k == c_CW'(NTAPS - 1));
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_mul_a    = '0;
        w_mul_b    = '0;
        w_add_a    = '0;
        w_add_b    = '0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next = S_MAC;
                end
            end
            S_MAC: begin
                if (w_issue) begin
                    w_mul_a = r_x[w_tap];
                    w_mul_b = r_coef[w_tap];
                end
                w_add_a = r_acc;
                w_add_b = w_prod;
                if (w_last) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_x[i]    <= '0;
                r_coef[i] <= '0;
            end
            r_acc       <= '0;
            r_k         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= bus.cfg_we && !w_cfg_ok;
            // Written before the shift so a same-cycle sample sees the new coefficient.
            if (w_cfg_ok) begin
                r_coef[bus.cfg_addr] <= bus.cfg_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = NTAPS - 1; i > 0; i--) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_x[0] <= bus.in_data;
                        r_k    <= '0;
                    end
                end
                S_MAC: begin
                    r_k <= r_k + c_CW'(1);
                    if (w_first) begin
                        r_acc <= w_prod;
                    end else if (w_consume) begin
                        r_acc <= bus.add_s;
                    end
                    if (w_last) begin
                        r_out_data  <= bus.add_s;
                        r_out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.mul_a     = w_mul_a;
    assign bus.mul_b     = w_mul_b;
    assign bus.add_a     = w_add_a;
    assign bus.add_b     = w_add_b;

endmodule

`default_nettype wire

// File: tb/tb_fp_fir_mac_sequencer.sv
// ============================================================================
// Module  : tb_fp_fir_mac_sequencer
// Purpose : Directed-vector bench for fp_fir_mac_sequencer with behavioural
//           single-precision multiplier/adder on the shared operator bus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_fir_mac_sequencer;

    localparam int NTAPS = 6;
    localparam int AW    = 3;
`ifdef FIR_SEQ_PROD_REG_EN
    localparam int c_LAT = NTAPS + 1;
`else
    localparam int c_LAT = NTAPS;
`endif

    localparam logic [31:0] c_F0P5 = 32'h3F000000;
    localparam logic [31:0] c_F1   = 32'h3F800000;
    localparam logic [31:0] c_F2   = 32'h40000000;
    localparam logic [31:0] c_F3P5 = 32'h40600000;
    localparam logic [31:0] c_F4   = 32'h40800000;
    localparam logic [31:0] c_F4P5 = 32'h40900000;
    localparam logic [31:0] c_F10  = 32'h41200000;

    logic Clk;
    logic Rst;
    int   n_cmp;
    int   n_fail;

    fp_fir_mac_sequencer_if #(.AW(AW)) bus ();

    fp_fir_mac_sequencer #(.NTAPS(NTAPS), .AW(AW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Normal numbers and zero only, which covers every value used here.
    function automatic real s2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    always_comb begin
        bus.mul_p = r2s(s2r(bus.mul_a) * s2r(bus.mul_b));
        bus.add_s = r2s(s2r(bus.add_a) + s2r(bus.add_b));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    endtask

    task automatic load_coefs();
        logic [31:0] tbl [NTAPS];
        tbl = '{c_F1, c_F2, c_F0P5, c_F1, 32'd0, 32'd0};
        for (int i = 0; i < NTAPS; i++) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = AW'(i);
            bus.cfg_data = tbl[i];
            tick();
        end
        bus.cfg_we = 1'b0;
        chk("cfg_load_err", 32'(bus.cfg_err), 32'd0);
    endtask

    task automatic send(input logic [31:0] x, output logic [31:0] y, output int lat);
        int w;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            tick();
            w++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        y = bus.out_data;
    endtask

    typedef struct {
        logic        rst_before;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [8];
        logic [31:0] y;
        int          lat;

        n_cmp  = 0;
        n_fail = 0;
        Rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;

        // Impulse then step response, coefficients {1, 2, 0.5, 1, 0, 0}.
        vecs[0] = '{1'b1, c_F1, c_F1};
        vecs[1] = '{1'b0, 32'd0, c_F2};
        vecs[2] = '{1'b0, 32'd0, c_F0P5};
        vecs[3] = '{1'b0, 32'd0, c_F1};
        vecs[4] = '{1'b1, c_F1, c_F1};
        vecs[5] = '{1'b0, c_F1, 32'h40400000};
        vecs[6] = '{1'b0, c_F1, c_F3P5};
        vecs[7] = '{1'b0, c_F1, c_F4P5};

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst_before) begin
                do_reset();
                load_coefs();
            end
            send(vecs[i].x, y, lat);
            chk($sformatf("vec%0d_data", i), y, vecs[i].y);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(c_LAT));
        end

        // Backpressure: delay line is all ones up to tap 3, so the next 1.0 gives 4.5.
        tick();
        bus.out_ready = 1'b0;
        send(c_F1, y, lat);
        chk("bp_data", y, c_F4P5);
        bus.in_valid = 1'b1;
        bus.in_data  = c_F2;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i),
                {bus.out_valid, bus.in_ready, bus.out_data[29:0]},
                {1'b1, 1'b0, c_F4P5[29:0]});
        end
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        send(32'd0, y, lat);
        chk("bp_no_overlap", y, c_F3P5);

        // Config rejection in MAC and for an out-of-range index.
        do_reset();
        load_coefs();
        bus.in_valid = 1'b1;
        bus.in_data  = c_F1;
        tick();
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd1;
        bus.cfg_data = c_F10;
        tick();
        bus.cfg_we = 1'b0;
        chk("cfg_mac_err", 32'(bus.cfg_err), 32'd1);
        tick();
        chk("cfg_mac_err_pulse", 32'(bus.cfg_err), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("cfg_mac_out", bus.out_data, c_F1);
        tick();
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd6;
        bus.cfg_data = c_F10;
        tick();
        bus.cfg_addr = 3'd7;
        chk("cfg_range6_err", 32'(bus.cfg_err), 32'd1);
        tick();
        bus.cfg_we = 1'b0;
        chk("cfg_range7_err", 32'(bus.cfg_err), 32'd1);
        tick();
        chk("cfg_range_pulse", 32'(bus.cfg_err), 32'd0);
        send(32'd0, y, lat);
        chk("cfg_coef1_kept", y, c_F2);
        tick();

        // Same-cycle write and sample: the new coefficient is used.
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd2;
        bus.cfg_data = c_F4;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd0;
        tick();
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
        chk("cfg_same_cycle_err", 32'(bus.cfg_err), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("cfg_same_cycle_out", bus.out_data, c_F4);
        tick();

        // Asynchronous reset while the MAC is at tap 2.
        do_reset();
        load_coefs();
        bus.in_valid = 1'b1;
        bus.in_data  = c_F1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2;
        Rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_mul_a", bus.mul_a, 32'd0);
        tick();
        Rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        load_coefs();
        send(c_F1, y, lat);
        chk("mid_rst_impulse", y, c_F1);
        chk("mid_rst_latency", 32'(lat), 32'(c_LAT));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
